// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared definitions for the plot framebuffer: geometry, address
//            and colour types, FSM state encodings, scan beat payload and the
//            raster address helper.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;    // 19200
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 15;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef logic [ADDR_W-1:0]   fb_addr_t;
    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [X_W-1:0]      fb_x_t;
    typedef logic [Y_W-1:0]      fb_y_t;

    localparam fb_addr_t LAST_ADDR = fb_addr_t'(FB_DEPTH - 1);
    localparam fb_x_t    LAST_X    = fb_x_t'(FB_W - 1);
    localparam fb_y_t    LAST_Y    = fb_y_t'(FB_H - 1);

    typedef enum logic [1:0] {
        CL_IDLE  = 2'd0,
        CL_SWEEP = 2'd1,
        CL_DONE  = 2'd2
    } clr_state_t;

    typedef enum logic [0:0] {
        SC_IDLE = 1'b0,
        SC_RUN  = 1'b1
    } scan_state_t;

    // One readout beat as carried through the skid buffer.
    typedef struct packed {
        fb_x_t   x;
        fb_y_t   y;
        colour_t colour;
        logic    last;
    } scan_beat_t;

    // y*160 + x, built from shifts so no multiplier is inferred.
    function automatic fb_addr_t fb_addr(input fb_x_t x, input fb_y_t y);
        fb_addr_t y_ext;
        y_ext = {{(ADDR_W-Y_W){1'b0}}, y};
        return (y_ext << 7) + (y_ext << 5) + {{(ADDR_W-X_W){1'b0}}, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_skid2.sv
`default_nettype none
// ============================================================================
// Module   : fb_skid2
// Purpose  : Two-entry valid/ready buffer for scan beats. The producer does
//            not look at a ready signal; it meters its own pushes from the
//            exported occupancy, so a push never arrives while full.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_data   - beat pushed this cycle
//            out_valid/out_ready/out_data - registered consumer side
//            occupancy          - entries currently held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module fb_skid2
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  scan_beat_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output scan_beat_t out_data,
    output logic [1:0] occupancy
);

    scan_beat_t r_ent0;     // head, drives the outputs
    scan_beat_t r_ent1;
    logic [1:0] r_count;

    logic w_push;
    logic w_pop;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_ent0;
    assign occupancy = r_count;
    assign w_push    = in_valid;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_ent0 <= in_data;
                    else                 r_ent1 <= in_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy is unchanged.
                    if (r_count == 2'd1) begin
                        r_ent0 <= in_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/plot_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : plot_framebuffer
// Purpose  : 160x120x3 framebuffer fed by the drawer plot interface, with a
//            full-frame clear sweep and a raster-order valid/ready readout.
// Ports    : clk, rst_n (sync, active-low)
//            vga_x/vga_y/vga_colour/vga_plot - pixel plot (no backpressure)
//            clear_start/clear_colour/clear_done - fill request handshake
//            scan_start, scan_ready, scan_valid, scan_x, scan_y,
//            scan_colour, scan_last, scan_busy - raster readout stream
//            plot_accepted_cnt/plot_dropped_cnt - only with PLOT_STATS_EN
// Options  : PLOT_STATS_EN - adds saturating plot accept/drop counters
// Revision : 1.0 - initial release
// ============================================================================
module plot_framebuffer
    import fb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                clear_start,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                clear_done,
    input  logic                scan_start,
    input  logic                scan_ready,
    output logic                scan_valid,
    output logic [7:0]          scan_x,
    output logic [6:0]          scan_y,
    output logic [COLOUR_W-1:0] scan_colour,
    output logic                scan_last,
    output logic                scan_busy
`ifdef PLOT_STATS_EN
    ,
    output logic [15:0]         plot_accepted_cnt,
    output logic [15:0]         plot_dropped_cnt
`endif
);

    // ------------------------------------------------------------------
    // Plot qualification
    // ------------------------------------------------------------------
    logic w_plot_legal;
    assign w_plot_legal = vga_plot && (vga_x < LAST_X + 8'd1) && (vga_y < LAST_Y + 7'd1);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    clr_state_t r_clr_state;
    clr_state_t w_clr_next;
    fb_addr_t   r_clr_addr;
    colour_t    r_clr_colour;
    logic       w_clr_accept;
    logic       w_sweep_wr;

    assign w_clr_accept = (r_clr_state == CL_IDLE) && clear_start;
    // A legal plot owns the single write port, so the sweep holds its address.
    assign w_sweep_wr   = (r_clr_state == CL_SWEEP) && !w_plot_legal;

    always_comb begin
        w_clr_next = r_clr_state;
        unique case (r_clr_state)
            CL_IDLE:  if (clear_start) w_clr_next = CL_SWEEP;
            CL_SWEEP: if (w_sweep_wr && (r_clr_addr == LAST_ADDR)) w_clr_next = CL_DONE;
            CL_DONE:  if (!clear_start) w_clr_next = CL_IDLE;
            default:  w_clr_next = CL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_state  <= CL_IDLE;
            r_clr_addr   <= '0;
            r_clr_colour <= '0;
        end else begin
            r_clr_state <= w_clr_next;
            if (w_clr_accept) begin
                r_clr_addr   <= '0;
                r_clr_colour <= clear_colour;
            end else if (w_sweep_wr) begin
                r_clr_addr <= r_clr_addr + fb_addr_t'(1);
            end
        end
    end

    assign clear_done = (r_clr_state == CL_DONE);

    // ------------------------------------------------------------------
    // Frame RAM: one write port, one registered read port. Read-during-
    // write to the same address returns the previous contents.
    // ------------------------------------------------------------------
    colour_t  r_mem [FB_DEPTH];
    logic     w_we;
    fb_addr_t w_wr_addr;
    colour_t  w_wr_data;
    logic     w_rd_en;
    fb_addr_t w_rd_addr;
    colour_t  r_rd_data;

    assign w_we      = w_plot_legal || w_sweep_wr;
    assign w_wr_addr = w_plot_legal ? fb_addr(vga_x, vga_y) : r_clr_addr;
    assign w_wr_data = w_plot_legal ? vga_colour : r_clr_colour;

    always_ff @(posedge clk) begin
        if (w_we)    r_mem[w_wr_addr] <= w_wr_data;
        if (w_rd_en) r_rd_data        <= r_mem[w_rd_addr];
    end

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    scan_state_t r_sc_state;
    scan_state_t w_sc_next;
    fb_x_t       r_rx;           // next pixel to issue; rests at (0,0) when idle
    fb_y_t       r_ry;
    logic        r_issue_done;
    logic        r_inflight;     // a RAM read issued last cycle lands now
    fb_x_t       r_p_x;
    fb_y_t       r_p_y;
    logic        r_p_last;
    logic [1:0]  w_occ;
    logic        w_sc_accept;
    logic        w_pop;
    logic [2:0]  w_credit;
    logic        w_issue;
    logic        w_issue_last;
    scan_beat_t  w_push_beat;
    scan_beat_t  w_out_beat;

    assign w_sc_accept  = (r_sc_state == SC_IDLE) && scan_start;
    assign w_pop        = scan_valid && scan_ready;
    // Entries the skid will hold after this edge; counting the pop keeps
    // the pipe full at one beat per cycle without ever overfilling.
    assign w_credit     = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    // The accept cycle issues pixel (0,0) itself, saving a cycle of latency.
    assign w_issue      = w_sc_accept ||
                          ((r_sc_state == SC_RUN) && !r_issue_done && (w_credit < 3'd2));
    assign w_issue_last = (r_rx == LAST_X) && (r_ry == LAST_Y);
    assign w_rd_en      = w_issue;
    assign w_rd_addr    = fb_addr(r_rx, r_ry);

    always_comb begin
        w_sc_next = r_sc_state;
        unique case (r_sc_state)
            SC_IDLE: if (scan_start) w_sc_next = SC_RUN;
            SC_RUN:  if (w_pop && scan_last) w_sc_next = SC_IDLE;
            default: w_sc_next = SC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sc_state   <= SC_IDLE;
            r_rx         <= '0;
            r_ry         <= '0;
            r_issue_done <= 1'b0;
            r_inflight   <= 1'b0;
            r_p_x        <= '0;
            r_p_y        <= '0;
            r_p_last     <= 1'b0;
        end else begin
            r_sc_state <= w_sc_next;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_p_x        <= r_rx;
                r_p_y        <= r_ry;
                r_p_last     <= w_issue_last;
                r_issue_done <= w_issue_last;
                if (w_issue_last) begin
                    r_rx <= '0;
                    r_ry <= '0;
                end else if (r_rx == LAST_X) begin
                    r_rx <= '0;
                    r_ry <= r_ry + fb_y_t'(1);
                end else begin
                    r_rx <= r_rx + fb_x_t'(1);
                end
            end
        end
    end

    assign w_push_beat = '{x: r_p_x, y: r_p_y, colour: r_rd_data, last: r_p_last};

    fb_skid2 u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_inflight),
        .in_data   (w_push_beat),
        .out_valid (scan_valid),
        .out_ready (scan_ready),
        .out_data  (w_out_beat),
        .occupancy (w_occ)
    );

    assign scan_x      = w_out_beat.x;
    assign scan_y      = w_out_beat.y;
    assign scan_colour = w_out_beat.colour;
    assign scan_last   = w_out_beat.last;
    assign scan_busy   = (r_sc_state == SC_RUN);

    // ------------------------------------------------------------------
    // Optional plot statistics
    // ------------------------------------------------------------------
`ifdef PLOT_STATS_EN
    logic [15:0] r_acc_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_plot_illegal;

    assign w_plot_illegal = vga_plot && !w_plot_legal;

    always_ff @(posedge clk) begin
        if (!rst_n || w_clr_accept) begin
            r_acc_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_plot_legal && (r_acc_cnt != 16'hFFFF))    r_acc_cnt  <= r_acc_cnt + 16'd1;
            if (w_plot_illegal && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign plot_accepted_cnt = r_acc_cnt;
    assign plot_dropped_cnt  = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_plot_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_plot_framebuffer
// Purpose  : Self-checking bench for plot_framebuffer. Keeps a plain array
//            image of the frame, drives clears, random plots and scans, and
//            compares every scan beat against the image in raster order.
// Options  : PLOT_STATS_EN - also checks the plot statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_plot_framebuffer;
    import fb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       clear_start;
    logic [2:0] clear_colour;
    logic       clear_done;
    logic       scan_start;
    logic       scan_ready;
    logic       scan_valid;
    logic [7:0] scan_x;
    logic [6:0] scan_y;
    logic [2:0] scan_colour;
    logic       scan_last;
    logic       scan_busy;
`ifdef PLOT_STATS_EN
    logic [15:0] acc_cnt;
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int exp_acc  = 0;
    int exp_drop = 0;
    logic [2:0] ref_fb [FB_DEPTH];

    always #5 clk = ~clk;

    plot_framebuffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .scan_start   (scan_start),
        .scan_ready   (scan_ready),
        .scan_valid   (scan_valid),
        .scan_x       (scan_x),
        .scan_y       (scan_y),
        .scan_colour  (scan_colour),
        .scan_last    (scan_last),
        .scan_busy    (scan_busy)
`ifdef PLOT_STATS_EN
        ,
        .plot_accepted_cnt (acc_cnt),
        .plot_dropped_cnt  (drop_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected beat n of a raster readout: position from n, colour from the image.
    function automatic logic [31:0] exp_beat(input int n);
        logic [7:0] x;
        logic [6:0] y;
        x = 8'(n % FB_W);
        y = 7'(n / FB_W);
        return {13'd0, x, y, ref_fb[n], (n == FB_DEPTH - 1)};
    endfunction

    task automatic plot(input int x, input int y, input logic [2:0] c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = c;
        vga_plot   = 1'b1;
        step();
        vga_plot   = 1'b0;
        if (x < FB_W && y < FB_H) begin
            ref_fb[y * FB_W + x] = c;
            exp_acc++;
        end else begin
            exp_drop++;
        end
    endtask

    // mode 0: ready toggles 1,0,1,0 from the start cycle; mode 1: random ready.
    // A redundant scan_start is pulsed mid-run and must be ignored.
    task automatic scan_run(input int mode, input int want, output int got);
        int cyc;
        bit prev_stall;
        bit first_seen;
        got        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        first_seen = 1'b0;
        scan_start = 1'b1;
        while (got < want && cyc < 80000) begin
            if (mode == 0) scan_ready = (cyc % 2 == 0);
            else           scan_ready = ($urandom_range(0, 3) != 0);
            if (cyc == 200) scan_start = 1'b1;
            if (prev_stall) check("hold_valid", {31'd0, scan_valid}, 32'd1);
            if (scan_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    check("first_valid_cycle", cyc, 2);
                end
                check($sformatf("beat%0d", got),
                      {13'd0, scan_x, scan_y, scan_colour, scan_last}, exp_beat(got));
                if (scan_ready) got++;
            end
            prev_stall = scan_valid && !scan_ready;
            step();
            scan_start = 1'b0;
            cyc++;
        end
        scan_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int got;
        logic [2:0] c;

        rst_n        = 1'b0;
        vga_x        = '0;
        vga_y        = '0;
        vga_colour   = '0;
        vga_plot     = 1'b0;
        clear_start  = 1'b0;
        clear_colour = '0;
        scan_start   = 1'b0;
        scan_ready   = 1'b0;
        repeat (3) step();

        // Reset state: every output low.
        check("reset_outputs",
              {12'd0, clear_done, scan_valid, scan_x, scan_y, scan_colour, scan_last, scan_busy}, 32'd0);
`ifdef PLOT_STATS_EN
        check("reset_stats", {acc_cnt, drop_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Clear to 010 while plotting (0,0) for 10 cycles mid-sweep: those
        // cycles stall the sweep, and the sweep later overwrites (0,0).
        clear_colour = 3'b010;
        clear_start  = 1'b1;
        cyc = 0;
        while (cyc < 25000) begin
            if (cyc >= 1 && cyc <= 10) begin
                vga_plot   = 1'b1;
                vga_x      = 8'd0;
                vga_y      = 7'd0;
                vga_colour = 3'b101;
            end else begin
                vga_plot = 1'b0;
            end
            if (cyc == 2) clear_colour = 3'b111;   // must already be latched
            step();
            cyc++;
            if (clear_done) break;
        end
        vga_plot = 1'b0;
        check("clear_done_cycles", cyc, FB_DEPTH + 1 + 10);
        for (int i = 0; i < FB_DEPTH; i++) ref_fb[i] = 3'b010;
        exp_acc  = 10;
        exp_drop = 0;
        step();
        check("clear_done_held", {31'd0, clear_done}, 32'd1);
        clear_start = 1'b0;
        step();
        check("clear_done_drop", {31'd0, clear_done}, 32'd0);

        // Directed and random plots, including out-of-range ones.
        plot(5, 7, 3'b101);
        plot(159, 119, 3'b111);
        plot(160, 0, 3'b011);
        plot(0, 120, 3'b011);
        for (int i = 0; i < 60; i++) begin
            c = 3'($urandom_range(0, 7));
            plot($urandom_range(0, 175), $urandom_range(0, 127), c);
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
        check("model_pix1125", {29'd0, ref_fb[1125]}, 32'd5);
`ifdef PLOT_STATS_EN
        check("stats_accepted", {16'd0, acc_cnt}, 32'(exp_acc));
        check("stats_dropped", {16'd0, drop_cnt}, 32'(exp_drop));
`endif

        // Full raster readout with ready toggling.
        scan_run(0, FB_DEPTH, got);
        check("scan_transfers", got, FB_DEPTH);
        check("scan_busy_after", {31'd0, scan_busy}, 32'd0);
        check("scan_valid_after", {31'd0, scan_valid}, 32'd0);

        // Partial scan, reset mid-scan, then a fresh scan from (0,0).
        scan_run(1, 300, got);
        check("partial_transfers", got, 300);
        check("busy_mid_scan", {31'd0, scan_busy}, 32'd1);
        rst_n = 1'b0;
        step();
        check("reset_mid_scan", {29'd0, scan_valid, scan_busy, clear_done}, 32'd0);
        rst_n = 1'b1;
        step();
        scan_run(1, 400, got);
        check("rescan_transfers", got, 400);

        // A clear that is accepted and then abandoned by reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        clear_colour = 3'b001;
        clear_start  = 1'b1;
        step();
        clear_start  = 1'b0;
`ifdef PLOT_STATS_EN
        check("stats_cleared_on_clear", {acc_cnt, drop_cnt}, 32'd0);
`endif
        repeat (20) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("abandoned_clear", {31'd0, clear_done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
